// File: rtl/cmp_pkg.sv
// Shared definitions for the look-ahead magnitude comparator family.
//   GROUP_W        : bits handled by one look-ahead first-difference cell
//   onehot_to_idx2 : 4-bit one-hot to 2-bit bit-position encoder
//   CMP_*          : compact result encoding for downstream sort blocks
package cmp_pkg;

    localparam int unsigned GROUP_W = 4;

    typedef logic [1:0] cmp_res_t;

    localparam cmp_res_t CMP_EQ = 2'b00;
    localparam cmp_res_t CMP_LT = 2'b01;
    localparam cmp_res_t CMP_GT = 2'b10;

    // An all-zero vector encodes to 0; callers only use the result when the group differs.
    function automatic logic [1:0] onehot_to_idx2(input logic [GROUP_W-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/look_ahead_logic_cell.sv
// 4-bit look-ahead first-difference cell.
// Ports:
//   a_i, b_i     : 4-bit operand slices
//   first_diff_o : one-hot marker of the most significant bit where a_i != b_i (0 if equal)
//   differs_o    : 1 when the slices differ anywhere
module look_ahead_logic_cell
    import cmp_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    output logic [GROUP_W-1:0] first_diff_o,
    output logic               differs_o
);

    logic [GROUP_W-1:0] x;

    assign x = a_i ^ b_i;

    // Flat MSB-first priority: every bit sees all higher XORs in parallel.
    assign first_diff_o[3] = x[3];
    assign first_diff_o[2] = x[2] & ~x[3];
    assign first_diff_o[1] = x[1] & ~(x[3] | x[2]);
    assign first_diff_o[0] = x[0] & ~(x[3] | x[2] | x[1]);

    assign differs_o = |x;

endmodule

// File: rtl/pipelined_lookahead_comparator.sv
// Two-stage pipelined signed/unsigned magnitude comparator with valid/ready handshake.
// Ports:
//   i_CLK, i_RST          : clock, asynchronous active-high reset
//   i_VALID, o_READY      : input handshake
//   i_SIGNED              : 1 = two's-complement compare, sampled with the operands
//   i_OPERAND_A/B         : WIDTH-bit operands
//   o_VALID, i_READY      : output handshake
//   o_GT, o_LT, o_EQ      : one-hot compare result (A vs B)
//   o_DIFF_IDX            : most significant differing bit position, 0 when equal
module pipelined_lookahead_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned  WIDTH   = 16,
    localparam int unsigned NGROUPS = WIDTH / GROUP_W,
    localparam int unsigned IDXW    = $clog2(WIDTH)
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic             i_SIGNED,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_GT,
    output logic             o_LT,
    output logic             o_EQ,
    output logic [IDXW-1:0]  o_DIFF_IDX
);

    if ((WIDTH % GROUP_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    // Stage 1: per-group look-ahead cells
    logic [NGROUPS-1:0]              grp_diff;
    logic [NGROUPS-1:0][GROUP_W-1:0] grp_oh;

    for (genvar g = 0; g < NGROUPS; g++) begin : g_cell
        look_ahead_logic_cell u_cell (
            .a_i          (i_OPERAND_A[g*GROUP_W +: GROUP_W]),
            .b_i          (i_OPERAND_B[g*GROUP_W +: GROUP_W]),
            .first_diff_o (grp_oh[g]),
            .differs_o    (grp_diff[g])
        );
    end

    logic                            s1_valid_q;
    logic [NGROUPS-1:0]              s1_diff_q;
    logic [NGROUPS-1:0][GROUP_W-1:0] s1_oh_q;
    logic [WIDTH-1:0]                s1_a_q;
    logic                            s1_signed_q;
    logic                            s1_msb_q;

    logic            out_valid_q;
    logic            gt_q;
    logic            lt_q;
    logic            eq_q;
    logic [IDXW-1:0] idx_q;

    logic s1_adv;
    logic s2_adv;

    // Ready is combinational from the output side so a full pipe still streams 1/cycle.
    assign s2_adv  = !out_valid_q || i_READY;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign o_READY = s1_adv;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_oh_q     <= '0;
            s1_a_q      <= '0;
            s1_signed_q <= 1'b0;
            s1_msb_q    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= i_VALID;
            if (i_VALID) begin
                s1_diff_q   <= grp_diff;
                s1_oh_q     <= grp_oh;
                s1_a_q      <= i_OPERAND_A;
                s1_signed_q <= i_SIGNED;
                s1_msb_q    <= i_OPERAND_A[WIDTH-1];
            end
        end
    end

    // Stage 2: group priority, index encode and result decision
    logic            any_diff;
    logic [IDXW-1:0] diff_idx;
    logic            a_bit;
    logic            gt_d;
    logic            lt_d;
    logic            eq_d;

    always_comb begin
        any_diff = |s1_diff_q;
        diff_idx = '0;
        // Ascending scan: the last hit is the most significant differing group.
        for (int g = 0; g < NGROUPS; g++) begin
            if (s1_diff_q[g]) begin
                diff_idx = IDXW'(g * GROUP_W) | IDXW'(onehot_to_idx2(s1_oh_q[g]));
            end
        end
        a_bit = s1_a_q[diff_idx];
        gt_d  = 1'b0;
        lt_d  = 1'b0;
        eq_d  = 1'b0;
        if (!any_diff) begin
            eq_d = 1'b1;
        end else if (s1_signed_q && diff_idx == IDXW'(WIDTH - 1)) begin
            // Sign bits differ: the negative operand is the smaller one.
            gt_d = ~s1_msb_q;
            lt_d = s1_msb_q;
        end else begin
            gt_d = a_bit;
            lt_d = ~a_bit;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            idx_q       <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            // Result fields only move on a real transfer; they hold otherwise.
            if (s1_valid_q) begin
                gt_q  <= gt_d;
                lt_q  <= lt_d;
                eq_q  <= eq_d;
                idx_q <= diff_idx;
            end
        end
    end

    assign o_VALID    = out_valid_q;
    assign o_GT       = gt_q;
    assign o_LT       = lt_q;
    assign o_EQ       = eq_q;
    assign o_DIFF_IDX = idx_q;

endmodule

// File: tb/tb_pipelined_lookahead_comparator.sv
// Directed and random checks of the pipelined comparator at WIDTH=16.
// Expected results are packed as {gt, lt, eq, idx[3:0]}.
module tb_pipelined_lookahead_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        signed_cmp;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic        gt;
    logic        lt;
    logic        eq;
    logic [3:0]  diff_idx;

    pipelined_lookahead_comparator #(
        .WIDTH (16)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_VALID     (in_valid),
        .o_READY     (in_ready),
        .i_SIGNED    (signed_cmp),
        .i_OPERAND_A (op_a),
        .i_OPERAND_B (op_b),
        .o_VALID     (out_valid),
        .i_READY     (out_ready),
        .o_GT        (gt),
        .o_LT        (lt),
        .o_EQ        (eq),
        .o_DIFF_IDX  (diff_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_out    = 0;
    int last_out_edge    = 0;
    int last_accept_edge = 0;
    logic [6:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
        logic [15:0] x;
        logic [3:0]  idx;
        logic        g;
        x   = a ^ b;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) if (x[i]) idx = 4'(i);
        if (x == 16'h0) return 7'b001_0000;
        g = s ? ($signed(a) > $signed(b)) : (a > b);
        return {g, ~g, 1'b0, idx};
    endfunction

    // Output monitor: looks just before each rising edge, when inputs and outputs are settled.
    always begin
        @(negedge clk);
        #4;
        if (out_ready && exp_q.size() == 0) begin
            check("no_spurious", {31'd0, out_valid}, 32'd0);
        end else if (out_valid && out_ready) begin
            check("result", {25'd0, gt, lt, eq, diff_idx}, {25'd0, exp_q[0]});
            void'(exp_q.pop_front());
            n_out++;
            last_out_edge = cyc + 1;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [6:0] exp);
        int waited = 0;
        in_valid   = 1'b1;
        op_a       = a;
        op_b       = b;
        signed_cmp = s;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            exp_q.push_back(exp);
            last_accept_edge = cyc + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int start_edge;
        int out_base;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        rst        = 1'b1;
        in_valid   = 1'b0;
        signed_cmp = 1'b0;
        op_a       = '0;
        op_b       = '0;
        out_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fields", {25'd0, gt, lt, eq, diff_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Latency: two cycles from accept to o_VALID
        send(16'h8000, 16'h7FFF, 1'b0, 7'b100_1111);
        #1;
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        @(negedge clk);

        // Directed vectors, back to back
        send(16'h8000, 16'h7FFF, 1'b1, 7'b010_1111);
        send(16'h0123, 16'h0127, 1'b1, 7'b010_0010);
        send(16'hBEEF, 16'hBEEF, 1'b0, 7'b001_0000);
        send(16'h0010, 16'h0001, 1'b0, 7'b100_0100);
        send(16'hFFFF, 16'h0001, 1'b1, 7'b010_1111);
        send(16'hFFFF, 16'h0001, 1'b0, 7'b100_1111);
        send(16'h00F0, 16'h00E0, 1'b1, 7'b100_0100);
        send(16'h1234, 16'h1235, 1'b1, 7'b010_0000);
        wait_drain();
        check("directed_count", n_out, 32'd9);

        // Backpressure: 4 compares, consumer stalls 3 cycles after the first result
        out_base = n_out;
        fork
            begin
                send(16'h0001, 16'h0002, 1'b0, 7'b010_0001);
                send(16'hFF00, 16'h0F00, 1'b1, 7'b010_1111);
                send(16'h4000, 16'h4000, 1'b1, 7'b001_0000);
                send(16'h0800, 16'h0400, 1'b0, 7'b100_1011);
            end
            begin
                int w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid && w < 10);
                check("bp_first_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #2;
                    check("bp_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_ready", {31'd0, in_ready}, 32'd0);
                    if (exp_q.size() != 0)
                        check("bp_hold", {25'd0, gt, lt, eq, diff_idx}, {25'd0, exp_q[0]});
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", n_out - out_base, 32'd4);

        // Reset with two transactions in flight
        send(16'h0002, 16'h0001, 1'b0, 7'b100_0001);
        send(16'h0003, 16'h0001, 1'b0, 7'b100_0001);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("postrst_valid", {31'd0, out_valid}, 32'd0);
        end
        check("postrst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Throughput: 100 random pairs streamed with no backpressure
        out_base   = n_out;
        start_edge = 0;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = (i % 10 == 0) ? ra : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
            if (i == 0) start_edge = last_accept_edge;
        end
        wait_drain();
        check("tp_count", n_out - out_base, 32'd100);
        check("tp_cycles", last_out_edge - start_edge, 32'd101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
